// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, optional parity check,
// show-ahead receive FIFO and sticky frame/parity/overrun flags.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | half-bit delay, then confirm the start bit is still low
// DATA   | sampling DATA_WIDTH data bits, LSB first
// PARITY | sampling the parity bit (only when PARITY_EN=1)
// STOP   | sampling the stop bit; push, parity error or frame error
// BREAK  | stop bit was low; wait for the line to return high
module uart_rx_fifo #(
   parameter int DATA_WIDTH  = 8,
   parameter int BAUD_PERIOD = 434,
   parameter int FIFO_DEPTH  = 4,
   parameter int PARITY_EN   = 0,
   parameter int PARITY_ODD  = 0
) (
   input  logic                          clk,
   input  logic                          rst_l,
   input  logic                          rx,
   output logic [DATA_WIDTH-1:0]         rd_data,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun,
   input  logic                          clr_err
);

   localparam int CNT_W  = $clog2(BAUD_PERIOD);
   localparam int BIT_W  = $clog2(DATA_WIDTH);
   localparam int ADDR_W = $clog2(FIFO_DEPTH);

   localparam logic [CNT_W-1:0]  FULL_RELOAD = CNT_W'(BAUD_PERIOD - 1);
   localparam logic [CNT_W-1:0]  HALF_RELOAD = CNT_W'(BAUD_PERIOD / 2 - 1);
   localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_WIDTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_CNT   = (ADDR_W + 1)'(FIFO_DEPTH);
   localparam logic              PAR_ON      = (PARITY_EN != 0);
   localparam logic              PAR_ODD     = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_t;

   state_t                state, state_nxt;
   logic                  rx_meta, rx_s, rx_d;
   logic [CNT_W-1:0]      baud_cnt, baud_nxt;
   logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
   logic [BIT_W-1:0]      bit_cnt, bit_nxt;
   logic                  par_bad, par_bad_nxt;
   logic                  tick;
   logic                  push, set_frame, set_parity;

   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
   logic [ADDR_W:0]       count;
   logic                  pop, push_ok, drop;

   assign tick = (state != IDLE) && (baud_cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         rx_meta    <= 1'b1;
         rx_s       <= 1'b1;
         rx_d       <= 1'b1;
         state      <= IDLE;
         baud_cnt   <= '0;
         shreg      <= '0;
         bit_cnt    <= '0;
         par_bad    <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         rx_meta  <= rx;
         rx_s     <= rx_meta;
         rx_d     <= rx_s;
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         shreg    <= shreg_nxt;
         bit_cnt  <= bit_nxt;
         par_bad  <= par_bad_nxt;
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // a new error in the same cycle as clr_err stays set
         frame_err  <= set_frame  | (frame_err  & ~clr_err);
         parity_err <= set_parity | (parity_err & ~clr_err);
         overrun    <= drop       | (overrun    & ~clr_err);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_l && push_ok) fifo_mem[wr_ptr] <= shreg;
   end

   always_comb begin
      state_nxt   = state;
      baud_nxt    = baud_cnt;
      shreg_nxt   = shreg;
      bit_nxt     = bit_cnt;
      par_bad_nxt = par_bad;
      push        = 1'b0;
      set_frame   = 1'b0;
      set_parity  = 1'b0;

      if (state != IDLE) baud_nxt = tick ? FULL_RELOAD : baud_cnt - 1'b1;

      case (state)
         IDLE: begin
            if (rx_d && !rx_s) begin
               state_nxt = START;
               baud_nxt  = HALF_RELOAD;
            end
         end
         START: begin
            if (tick) begin
               if (!rx_s) begin
                  state_nxt   = DATA;
                  bit_nxt     = '0;
                  par_bad_nxt = 1'b0;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         DATA: begin
            if (tick) begin
               shreg_nxt = {rx_s, shreg[DATA_WIDTH-1:1]};
               bit_nxt   = bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) state_nxt = PAR_ON ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (tick) begin
               par_bad_nxt = (rx_s != ((^shreg) ^ PAR_ODD));
               state_nxt   = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               if (rx_s) begin
                  if (par_bad) set_parity = 1'b1;
                  else         push       = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  set_frame = 1'b1;
                  state_nxt = BREAK;
               end
            end
         end
         BREAK: begin
            if (rx_s) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // a full FIFO still accepts a character when the head leaves in the same cycle
   assign pop     = rd_valid & rd_ready;
   assign push_ok = push & ((count < DEPTH_CNT) | pop);
   assign drop    = push & ~push_ok;

   assign rd_valid = (count != '0);
   assign rd_data  = rd_valid ? fifo_mem[rd_ptr] : '0;
   assign rx_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: one instance without parity, one with odd parity;
// frames are built bit by bit and expected characters/flags come from frame contents.
module tb_uart_rx_fifo;

   localparam int BP    = 16;
   localparam int W     = 8;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_l = 1'b0;
   logic clr_err = 1'b0;
   logic rd_ready = 1'b0;
   logic rx0 = 1'b1;
   logic rx1 = 1'b1;

   logic [W-1:0] rd_data0, rd_data1;
   logic         rd_valid0, rd_valid1;
   logic [2:0]   rx_count0, rx_count1;
   logic         fe0, fe1, pe0, pe1, ov0, ov1;

   int checks = 0;
   int failures = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   bit fe_exp [2];
   bit pe_exp [2];
   bit ov_exp [2];
   bit force_rd = 1'b0;
   bit rand_rd = 1'b0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.DATA_WIDTH(W), .BAUD_PERIOD(BP), .FIFO_DEPTH(DEPTH),
                  .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
      .clk(clk), .rst_l(rst_l), .rx(rx0), .rd_data(rd_data0), .rd_valid(rd_valid0),
      .rd_ready(rd_ready), .rx_count(rx_count0), .frame_err(fe0), .parity_err(pe0),
      .overrun(ov0), .clr_err(clr_err));

   uart_rx_fifo #(.DATA_WIDTH(W), .BAUD_PERIOD(BP), .FIFO_DEPTH(DEPTH),
                  .PARITY_EN(1), .PARITY_ODD(1)) u_dut1 (
      .clk(clk), .rst_l(rst_l), .rx(rx1), .rd_data(rd_data1), .rd_valid(rd_valid1),
      .rd_ready(rd_ready), .rx_count(rx_count1), .frame_err(fe1), .parity_err(pe1),
      .overrun(ov1), .clr_err(clr_err));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] cnt_of(input int d);
      return (d == 0) ? 32'(rx_count0) : 32'(rx_count1);
   endfunction
   function automatic logic [31:0] fe_of(input int d);
      return (d == 0) ? 32'(fe0) : 32'(fe1);
   endfunction
   function automatic logic [31:0] pe_of(input int d);
      return (d == 0) ? 32'(pe0) : 32'(pe1);
   endfunction
   function automatic logic [31:0] ov_of(input int d);
      return (d == 0) ? 32'(ov0) : 32'(ov1);
   endfunction
   function automatic logic [31:0] data_of(input int d);
      return (d == 0) ? 32'(rd_data0) : 32'(rd_data1);
   endfunction
   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   task automatic set_rx(input int d, input logic v);
      if (d == 0) rx0 = v;
      else        rx1 = v;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_push(input int d, input logic [7:0] v);
      if (qsize(d) < DEPTH) begin
         if (d == 0) q0.push_back(v);
         else        q1.push_back(v);
      end else begin
         ov_exp[d] = 1'b1;
      end
   endtask

   task automatic check_state(input int d);
      check($sformatf("dut%0d_rx_count", d), cnt_of(d), 32'(qsize(d)));
      check($sformatf("dut%0d_frame_err", d), fe_of(d), 32'(fe_exp[d]));
      check($sformatf("dut%0d_parity_err", d), pe_of(d), 32'(pe_exp[d]));
      check($sformatf("dut%0d_overrun", d), ov_of(d), 32'(ov_exp[d]));
   endtask

   // Stop-bit sample lands on edge 11 of the stop bit: 2 sync flops + half-bit delay.
   task automatic send_frame(input int d, input logic [7:0] data, input bit par_flip,
                             input bit stop_val, input bit pop_at_stop);
      logic par_bit;
      set_rx(d, 1'b0);
      idle(BP);
      for (int i = 0; i < W; i++) begin
         set_rx(d, data[i]);
         idle(BP);
      end
      if (d == 1) begin
         par_bit = ~(^data) ^ par_flip;
         set_rx(d, par_bit);
         idle(BP);
      end
      set_rx(d, stop_val);
      for (int j = 1; j <= BP; j++) begin
         @(posedge clk);
         #1;
         if (j == 10) begin
            check($sformatf("dut%0d_count_before_push", d), cnt_of(d), 32'(qsize(d)));
            if (pop_at_stop) force_rd = 1'b1;
         end
         if (j == 11) begin
            force_rd = 1'b0;
            if (!stop_val)                  fe_exp[d] = 1'b1;
            else if (d == 1 && par_flip)    pe_exp[d] = 1'b1;
            else                            model_push(d, data);
            check_state(d);
            if (qsize(d) > 0)
               check($sformatf("dut%0d_head_data", d), data_of(d),
                     (d == 0) ? 32'(q0[0]) : 32'(q1[0]));
         end
      end
      if (!stop_val) begin
         idle(40 - BP);
         set_rx(d, 1'b1);
         idle(6);
      end else begin
         idle(2);
      end
   endtask

   task automatic drain();
      force_rd = 1'b1;
      idle(DEPTH * 2);
      force_rd = 1'b0;
      idle(2);
      check_state(0);
      check_state(1);
   endtask

   task automatic clear_errors();
      clr_err = 1'b1;
      idle(1);
      clr_err = 1'b0;
      for (int d = 0; d < 2; d++) begin
         fe_exp[d] = 1'b0;
         pe_exp[d] = 1'b0;
         ov_exp[d] = 1'b0;
      end
      idle(1);
      check_state(0);
      check_state(1);
   endtask

   task automatic check_reset_outputs();
      check("rst_rd_valid0", 32'(rd_valid0), 0);
      check("rst_rd_valid1", 32'(rd_valid1), 0);
      check("rst_rd_data0", 32'(rd_data0), 0);
      check("rst_rd_data1", 32'(rd_data1), 0);
      check("rst_rx_count0", 32'(rx_count0), 0);
      check("rst_rx_count1", 32'(rx_count1), 0);
      check("rst_flags0", {29'd0, fe0, pe0, ov0}, 0);
      check("rst_flags1", {29'd0, fe1, pe1, ov1}, 0);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #2;
         rd_ready = force_rd | (rand_rd & ($urandom_range(0, 1) == 1));
      end
   end

   // Monitor: a pop happens at the next edge whenever rd_ready is high and data is expected.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (rst_l && rd_ready) begin
            if (q0.size() > 0) begin
               e = q0.pop_front();
               check("dut0_pop_valid", 32'(rd_valid0), 1);
               check("dut0_pop_data", 32'(rd_data0), 32'(e));
            end else begin
               check("dut0_empty_valid", 32'(rd_valid0), 0);
            end
            if (q1.size() > 0) begin
               e = q1.pop_front();
               check("dut1_pop_valid", 32'(rd_valid1), 1);
               check("dut1_pop_data", 32'(rd_data1), 32'(e));
            end else begin
               check("dut1_empty_valid", 32'(rd_valid1), 0);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, failures so far %0d", failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      logic [7:0] v;
      bit flip, stop_ok;

      idle(3);
      check_reset_outputs();
      rst_l = 1'b1;
      idle(5);

      // basic character and pop
      send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b0);
      drain();

      // false start: 4-cycle glitch
      set_rx(0, 1'b0);
      idle(4);
      set_rx(0, 1'b1);
      idle(30);
      check_state(0);
      send_frame(0, 8'h69, 1'b0, 1'b1, 1'b0);
      drain();

      // frame error with a long break, then recovery
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
      check_state(0);
      send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0);
      drain();
      clear_errors();

      // odd parity: good and bad parity bit
      send_frame(1, 8'h07, 1'b0, 1'b1, 1'b0);
      send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0);
      drain();
      clear_errors();

      // overrun with no reads
      for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b0, 1'b1, 1'b0);
      check_state(0);
      drain();
      clear_errors();

      // full FIFO with a pop coinciding with the fifth push
      for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 1'b0, 1'b1, 1'b0);
      send_frame(0, 8'h05, 1'b0, 1'b1, 1'b1);
      check_state(0);
      drain();

      // randomized traffic with random reads
      rand_rd = 1'b1;
      for (int n = 0; n < 24; n++) begin
         d = int'($urandom_range(0, 1));
         v = 8'($urandom_range(0, 255));
         flip = (d == 1) && ($urandom_range(0, 3) == 0);
         stop_ok = ($urandom_range(0, 5) != 0);
         send_frame(d, v, flip, stop_ok, 1'b0);
      end
      rand_rd = 1'b0;
      idle(2);
      drain();
      clear_errors();

      // reset during the 4th data bit
      send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0);
      send_frame(1, 8'h55, 1'b0, 1'b0, 1'b0);
      v = 8'h96;
      set_rx(0, 1'b0);
      idle(BP);
      for (int i = 0; i < 3; i++) begin
         set_rx(0, v[i]);
         idle(BP);
      end
      set_rx(0, v[3]);
      idle(8);
      rst_l = 1'b0;
      set_rx(0, 1'b1);
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
         fe_exp[k] = 1'b0;
         pe_exp[k] = 1'b0;
         ov_exp[k] = 1'b0;
      end
      idle(2);
      check_reset_outputs();
      rst_l = 1'b1;
      idle(20);
      check_state(0);
      send_frame(0, 8'hC3, 1'b0, 1'b1, 1'b0);
      send_frame(1, 8'h81, 1'b0, 1'b1, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have the parameter DATA_WIDTH, default 8: data bits per character (5..16).
REQ-002 The block SHALL have the parameter BAUD_PERIOD, default 434: clk cycles per bit (>=8).
REQ-003 The block SHALL have the parameter FIFO_DEPTH, default 4: receive FIFO entries (power of 2, >=2).
REQ-004 The block SHALL have the parameter PARITY_EN, default 0: 1 = a parity bit follows the data bits.
REQ-005 The block SHALL have the parameter PARITY_ODD, default 0: 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
REQ-006 The block SHALL have the port clk, input, 1: the single clock; all logic on posedge.
REQ-007 The block SHALL have the port rst_l, input, 1: synchronous, active-low reset.
REQ-008 The block SHALL have the port rx, input, 1: asynchronous serial line, idle high.
REQ-009 The block SHALL have the port rd_data, output, DATA_WIDTH: FIFO head character, valid when rd_valid=1.
REQ-010 The block SHALL have the port rd_valid, output, 1: FIFO not empty.
REQ-011 The block SHALL have the port rd_ready, input, 1: pop request; a pop occurs when rd_valid & rd_ready.
REQ-012 The block SHALL have the port rx_count, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-013 The block SHALL have the port frame_err, output, 1: sticky; a stop bit was sampled low.
REQ-014 The block SHALL have the port parity_err, output, 1: sticky; a parity mismatch occurred.
REQ-015 The block SHALL have the port overrun, output, 1: sticky; a good character was dropped because the FIFO was full.
REQ-016 The block SHALL have the port clr_err, input, 1: clears all three sticky error flags.

Function
REQ-017 The block SHALL pass rx through a 2-flop synchronizer; the synchronized value is rx_s, and prior-cycle rx_s is rx_d.
REQ-018 The block SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-019 In IDLE, the block SHALL enter START on rx_d=1 & rx_s=0 and load baud_cnt = BAUD_PERIOD/2 - 1.
REQ-020 In all states other than IDLE, the block SHALL decrement baud_cnt each cycle and take a sample ("tick") when baud_cnt=0; each tick reloads baud_cnt = BAUD_PERIOD - 1.
REQ-021 On the START tick, the block SHALL enter DATA if rx_s=0, else return to IDLE (false start), with no flags and no push.
REQ-022 In DATA, the block SHALL shift rx_s in LSB-first on each tick and, after DATA_WIDTH ticks, enter PARITY if PARITY_EN=1, else STOP.
REQ-023 On the PARITY tick, the block SHALL compare rx_s against the XOR of the data bits, inverted when PARITY_ODD=1, and record any mismatch.
REQ-024 On the STOP tick with rx_s=1, the block SHALL push the character if no parity mismatch was recorded, set parity_err otherwise, and return to IDLE.
REQ-025 On the STOP tick with rx_s=0, the block SHALL set frame_err, discard the character, and enter BREAK.
REQ-026 BREAK SHALL remain until rx_s=1, then go to IDLE; no falling edge is detected while in BREAK.
REQ-027 A push SHALL be accepted when rx_count < FIFO_DEPTH, or when a pop occurs in the same cycle; otherwise the character SHALL be dropped and overrun set.
REQ-028 rd_valid and rd_data SHALL update in the cycle after the STOP tick (push latency 1 clk); rd_data SHALL be show-ahead, with no read latency.
REQ-029 A simultaneous push and pop SHALL leave rx_count unchanged; a pop when empty SHALL be ignored.
REQ-030 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, and rx_count SHALL never exceed FIFO_DEPTH.
REQ-031 If an error set and clr_err occur in the same cycle, set SHALL win.

Reset
REQ-032 While rst_l=0 at posedge clk, the block SHALL apply: state=IDLE, synchronizer flops=1, baud_cnt=0, FIFO empty, rx_count=0, rd_valid=0, rd_data=0, frame_err=parity_err=overrun=0.
REQ-033 Reset asserted mid-frame SHALL abandon the character with no push and no flags; the first falling edge after reset release starts a new frame.

Verification
REQ-034 With BAUD_PERIOD=16, DATA_WIDTH=8, PARITY_EN=0: send 0xA5 -> rd_valid=1 one cycle after the STOP tick, rd_data=0xA5, rx_count=1; pop -> rd_valid=0.
REQ-035 Drive rx low for 4 cycles, then high -> false start, no push, no flags, state back in IDLE.
REQ-036 Send 0x3C with stop bit 0, holding rx low 40 cycles -> frame_err=1, rx_count=0; next 0x11 is received correctly; clr_err -> frame_err=0.
REQ-037 With PARITY_EN=1, PARITY_ODD=1: send 0x07 with parity bit 0 -> pushed; send 0x07 with parity bit 1 -> parity_err=1, not pushed.
REQ-038 With FIFO_DEPTH=4 and no reads: send 0x01..0x05 -> rx_count=4, overrun=1, pops return 0x01..0x04; repeat with a pop coinciding with the 5th push -> no overrun.
REQ-039 Assert rst_l=0 during the 4th data bit of a character -> all outputs at reset values, and the following character is received correctly.
